// File: rtl/mux1hot_pipe.sv
// mux1hot_pipe: N-input one-hot multiplexer with a single registered output stage.
// Latency: one cycle from accept (in_valid && in_ready) to out_valid; one transfer per cycle.
// Backpressure: in_ready = !out_valid || out_ready, so a full stage refills in the cycle it drains.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_data, sel        - N packed WIDTH-bit inputs (input k at [k*WIDTH +: WIDTH]) and one-hot select
//   in_valid, in_ready  - input handshake
//   out_data, out_valid - registered selected data, output handshake with out_ready
//   err, err_cnt        - illegal-select pulse and saturating count
//
// Build option: define MUX1HOT_PIPE_SELECT_CHECK_EN to drop and count non-one-hot selects.
// Without it every select is forwarded as the AND-OR of the selected inputs and err/err_cnt read 0.

module mux1hot_pipe #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               err,
   output logic [CNT_W-1:0]   err_cnt
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] mux_dat;
   logic             accept;
   logic             sel_legal;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // AND-OR mux: a multi-hot select ORs its inputs, a zero select gives 0.
   always_comb begin
      mux_dat = '0;
      for (int k = 0; k < N; k++) begin
         if (sel[k]) begin
            mux_dat = mux_dat | in_data[k*WIDTH +: WIDTH];
         end
      end
   end

`ifdef MUX1HOT_PIPE_SELECT_CHECK_EN
   localparam logic [N-1:0]     SEL_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
   assign sel_legal = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);

   always_comb begin
      err_d     = accept && !sel_legal;
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err     = err_q;
   assign err_cnt = err_cnt_q;
`else
   assign sel_legal = 1'b1;
   assign err       = 1'b0;
   assign err_cnt   = '0;
`endif

   // A drain clears the entry; a legal accept in the same cycle overrides it.
   // An illegal accept leaves out_valid to the drain term alone.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept && sel_legal) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule
